// File: rtl/iob_pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input in
// clk cycles, and flags an input that stays constant for a full counter span.
module iob_pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_input,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             stuck_o,
  output logic             level_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_high_cnt;

  logic                   w_sync;
  logic                   w_rise;
  logic                   w_fall;
  logic [CNT_W-1:0]       w_cnt_inc;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [CNT_W-1:0]       w_high_cnt_nxt;
  logic [CNT_W-1:0]       w_period_nxt;
  logic [CNT_W-1:0]       w_high_out_nxt;
  logic                   w_valid_nxt;
  logic                   w_stuck_nxt;
  logic                   w_level_nxt;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = w_sync & ~r_hist;
  assign w_fall = ~w_sync & r_hist;
  // Saturate so the counter can never wrap, even on a fall at the last count.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? CNT_MAX : (r_cnt + CNT_ONE);

  // Input synchronizer and edge-history flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync <= {SYNC_STAGES{1'b0}};
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_input};
      r_hist <= w_sync;
    end
  end

  // Next-state, counter and measurement-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_high_cnt_nxt = r_high_cnt;
    w_period_nxt   = period_o;
    w_high_out_nxt = high_o;
    w_valid_nxt    = 1'b0;
    w_stuck_nxt    = stuck_o;
    w_level_nxt    = level_o;
    if (!en) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = CNT_ZERO;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = ARM;
          w_cnt_nxt   = CNT_ZERO;
        end
        ARM: begin
          // The first rising edge only establishes phase.
          if (w_rise) begin
            w_state_nxt = HIGH;
            w_cnt_nxt   = CNT_ONE;
          end else begin
            w_cnt_nxt   = CNT_ZERO;
          end
        end
        HIGH: begin
          if (w_fall) begin
            w_state_nxt    = LOW;
            w_high_cnt_nxt = r_cnt;
            w_cnt_nxt      = w_cnt_inc;
          end else if (r_cnt == CNT_MAX) begin
            w_state_nxt    = ARM;
            w_cnt_nxt      = CNT_ZERO;
            w_stuck_nxt    = 1'b1;
            w_level_nxt    = w_sync;
            w_period_nxt   = CNT_ZERO;
            w_high_out_nxt = CNT_ZERO;
          end else begin
            w_cnt_nxt      = w_cnt_inc;
          end
        end
        LOW: begin
          if (w_rise) begin
            w_state_nxt    = HIGH;
            w_cnt_nxt      = CNT_ONE;
            w_period_nxt   = r_cnt;
            w_high_out_nxt = r_high_cnt;
            w_valid_nxt    = 1'b1;
            w_stuck_nxt    = 1'b0;
          end else if (r_cnt == CNT_MAX) begin
            w_state_nxt    = ARM;
            w_cnt_nxt      = CNT_ZERO;
            w_stuck_nxt    = 1'b1;
            w_level_nxt    = w_sync;
            w_period_nxt   = CNT_ZERO;
            w_high_out_nxt = CNT_ZERO;
          end else begin
            w_cnt_nxt      = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= CNT_ZERO;
      r_high_cnt <= CNT_ZERO;
      period_o   <= CNT_ZERO;
      high_o     <= CNT_ZERO;
      valid_o    <= 1'b0;
      stuck_o    <= 1'b0;
      level_o    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_high_cnt <= w_high_cnt_nxt;
      period_o   <= w_period_nxt;
      high_o     <= w_high_out_nxt;
      valid_o    <= w_valid_nxt;
      stuck_o    <= w_stuck_nxt;
      level_o    <= w_level_nxt;
    end
  end

endmodule

// File: tb/tb_iob_pwm_capture.sv
// Directed bench for iob_pwm_capture: expected measurements are queued as each
// rising edge is driven and compared whenever valid_o pulses.
module tb_iob_pwm_capture;

  localparam int TB_W = 8;

  logic            clk;
  logic            rst;
  logic            en;
  logic            pwm_input;
  logic [TB_W-1:0] period_o;
  logic [TB_W-1:0] high_o;
  logic            valid_o;
  logic            stuck_o;
  logic            level_o;

  typedef struct {
    int p;
    int h;
    int gap;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_valid = 0;

  iob_pwm_capture #(.CNT_W(TB_W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pwm_input (pwm_input),
    .period_o  (period_o),
    .high_o    (high_o),
    .valid_o   (valid_o),
    .stuck_o   (stuck_o),
    .level_o   (level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (valid_o === 1'b1) begin
      chk("valid_expected", (q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("period", period_o, e.p);
        chk("high", high_o, e.h);
        chk("stuck_clear_on_valid", stuck_o, 32'd0);
        if (e.gap != 0) chk("valid_gap", cyc - last_valid, e.gap);
      end
      last_valid = cyc;
    end
  end

  task automatic push_exp(input int p, input int h, input int g);
    exp_t e;
    e.p = p;
    e.h = h;
    e.gap = g;
    q.push_back(e);
  endtask

  task automatic hold(input logic v, input int n);
    pwm_input = v;
    repeat (n) @(negedge clk);
  endtask

  // k periods; the first n_arm rising edges produce no measurement.
  task automatic wave(input int p, input int h, input int k, input int n_arm);
    for (int i = 0; i < k; i++) begin
      if (i >= n_arm) push_exp(p, h, (i > n_arm) ? p : 0);
      hold(1'b1, h);
      hold(1'b0, p - h);
    end
  endtask

  task automatic rearm();
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    en = 1'b0;
    pwm_input = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_period", period_o, 32'd0);
    chk("rst_high", high_o, 32'd0);
    chk("rst_valid", valid_o, 32'd0);
    chk("rst_stuck", stuck_o, 32'd0);
    chk("rst_level", level_o, 32'd0);
    rst = 1'b1;
    en = 1'b1;
    @(negedge clk);

    // Nominal waveform, then the minimum legal waveform.
    wave(100, 25, 4, 1);
    rearm();
    wave(4, 2, 6, 1);
    rearm();

    // Input stuck low after a measurement, then recovery.
    wave(50, 10, 2, 1);
    hold(1'b0, 300);
    chk("stuck_lo_flag", stuck_o, 32'd1);
    chk("stuck_lo_level", level_o, 32'd0);
    chk("stuck_lo_period", period_o, 32'd0);
    chk("stuck_lo_high", high_o, 32'd0);
    wave(50, 10, 3, 1);
    chk("recover_stuck", stuck_o, 32'd0);
    chk("recover_level", level_o, 32'd0);
    rearm();

    // Input stuck high from arming: no measurement, stuck with level 1.
    hold(1'b1, 300);
    chk("stuck_hi_flag", stuck_o, 32'd1);
    chk("stuck_hi_level", level_o, 32'd1);
    chk("stuck_hi_period", period_o, 32'd0);
    chk("stuck_hi_high", high_o, 32'd0);
    hold(1'b0, 5);
    wave(40, 20, 3, 1);
    chk("level_held", level_o, 32'd1);
    chk("stuck_cleared", stuck_o, 32'd0);

    // Enable dropped mid-high: outputs hold, two fresh rising edges needed.
    push_exp(40, 20, 40);
    hold(1'b1, 10);
    en = 1'b0;
    hold(1'b1, 5);
    chk("en_off_period", period_o, 32'd40);
    chk("en_off_high", high_o, 32'd20);
    chk("en_off_valid", valid_o, 32'd0);
    en = 1'b1;
    hold(1'b1, 5);
    hold(1'b0, 20);
    wave(40, 20, 3, 1);

    // Reset pulse mid-low: everything clears, first edge after only arms.
    push_exp(40, 20, 40);
    hold(1'b1, 10);
    hold(1'b0, 5);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_period", period_o, 32'd0);
    chk("midrst_high", high_o, 32'd0);
    chk("midrst_valid", valid_o, 32'd0);
    chk("midrst_stuck", stuck_o, 32'd0);
    chk("midrst_level", level_o, 32'd0);
    rst = 1'b1;
    hold(1'b0, 5);
    wave(40, 20, 3, 1);

    hold(1'b0, 10);
    chk("sb_drain", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_pwm_capture.md
IOB_PWM_CAPTURE -- requirements
Module: iob_pwm_capture

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of all cycle counters and measurement outputs (legal 4..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of flip-flops in the input synchronizer (legal 2..3).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port en  input  1  capture enable; 0 forces IDLE.
REQ-006 SHALL have port pwm_input  input  1  asynchronous PWM waveform to measure.
REQ-007 SHALL have port period_o  output  CNT_W  last measured period, in clk cycles, rising edge to rising edge.
REQ-008 SHALL have port high_o  output  CNT_W  last measured high time, in clk cycles, rising edge to falling edge.
REQ-009 SHALL have port valid_o  output  1  one-cycle pulse when period_o/high_o update with a new measurement.
REQ-010 SHALL have port stuck_o  output  1  input held constant for 2^CNT_W-1 cycles (0% or 100% duty).
REQ-011 SHALL have port level_o  output  1  synchronized input level captured at stuck detection.

Function
REQ-012 SHALL pass pwm_input through SYNC_STAGES flip-flops plus one edge-history flip-flop; rise_det = sync high and history low; fall_det = sync low and history high.
REQ-013 SHALL implement FSM states IDLE, ARM, HIGH, LOW.
REQ-014 SHALL go from IDLE to ARM when en=1; from any state to IDLE in the cycle after en=0.
REQ-015 SHALL go from ARM to HIGH on rise_det, without asserting valid_o (first edge only establishes phase).
REQ-016 SHALL go from HIGH to LOW on fall_det, latching an internal high count equal to cnt.
REQ-017 SHALL go from LOW to HIGH on rise_det, loading period_o with cnt and high_o with the latched high count.
REQ-018 SHALL assert valid_o for exactly the cycle after the LOW-to-HIGH rise_det, i.e. the cycle period_o/high_o first show the new values.
REQ-019 SHALL operate cycle counter cnt as follows: cnt set to 1 in every rise_det cycle; incremented by 1 otherwise in HIGH/LOW; held at 0 in IDLE/ARM.
REQ-020 SHALL, for a waveform with rise_det events N cycles apart and fall_det H cycles after rise, report period_o=N and high_o=H.
REQ-021 SHALL take the stuck path when cnt reaches 2^CNT_W-1 in HIGH or LOW without the exiting edge: stuck_o=1, level_o=synchronized level, period_o=0, high_o=0, no valid_o, next state ARM. Counters never wrap.
REQ-022 SHALL clear stuck_o on the next valid_o assertion only; level_o holds its value until the next stuck event.
REQ-023 SHALL, when rise_det and fall_det would both apply (glitch narrower than one cycle is filtered by synchronizer), act only on the edge matching the current state; edges not matching the state are ignored.
REQ-024 SHALL hold period_o, high_o, stuck_o, level_o while in IDLE or ARM; valid_o=0 there.
REQ-025 SHALL have no combinational path from any input to any output; all outputs registered.

Reset
REQ-026 SHALL, with rst=0 at a clk edge: FSM=IDLE, cnt=0, synchronizer/history flops=0, period_o=0, high_o=0, valid_o=0, stuck_o=0, level_o=0.
REQ-027 SHALL, when reset is asserted mid-measurement, discard the partial measurement; the first rising edge after release is treated as an ARM edge.

Verification
REQ-028 SHALL be verified as follows: en=1, pwm period 100, high 25, CNT_W=16 -> first valid_o after 2nd rising edge, period_o=100, high_o=25, every 100 cycles thereafter.
REQ-029 SHALL be verified as follows: pwm held low 70000 cycles, CNT_W=16 -> stuck_o=1, level_o=0, period_o=0, high_o=0 at cnt=65535; resume period 50 high 10 -> stuck_o clears with valid_o, period_o=50, high_o=10.
REQ-030 SHALL be verified as follows: pwm held high 70000 cycles -> stuck_o=1, level_o=1; no valid_o pulses.
REQ-031 SHALL be verified as follows: period 40 high 20, drop en for 5 cycles mid-high -> outputs hold, valid_o=0 until two further rising edges, then period_o=40, high_o=20.
REQ-032 SHALL be verified as follows: rst=0 for one cycle mid-LOW -> all outputs 0 next cycle; first post-reset rising edge gives no valid_o.
REQ-033 SHALL be verified as follows: minimum waveform period 4 high 2 -> period_o=4, high_o=2 each period, valid_o every 4 cycles.
